// File: rtl/sn_window_decoder.sv
// Stochastic bitstream back-converter: counts ones over WINDOW qualified bits and
// presents the count on a valid/ready register. Optional SN_BIPOLAR_EN adds bip_out.
module sn_window_decoder #(
  parameter int unsigned WINDOW = 8,
  parameter int unsigned CNT_W  = $clog2(WINDOW + 1),
  parameter int unsigned SMP_W  = $clog2(WINDOW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sn_bit,
  input  logic             sn_valid,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  input  logic             count_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             ovr_clr
`ifdef SN_BIPOLAR_EN
  ,
  output logic signed [CNT_W:0] bip_out
`endif
);

`ifdef SN_BIPOLAR_EN
  localparam int unsigned BIP_W = CNT_W + 1;
`endif

  typedef enum logic [0:0] {IDLE, ACCUM} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   acc, acc_n;
  logic [SMP_W-1:0]   smp, smp_n;
  logic [CNT_W-1:0]   cnt_n;
  logic               vld_n;
  logic               ovr_n;
  logic               done;
  logic [CNT_W-1:0]   result;

  // State, accumulator and output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      smp         <= '0;
      count_out   <= '0;
      count_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
`ifdef SN_BIPOLAR_EN
      bip_out     <= $signed(BIP_W'(0) - BIP_W'(WINDOW));
`endif
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      smp         <= smp_n;
      count_out   <= cnt_n;
      count_valid <= vld_n;
      busy        <= (state_n == ACCUM);
      overrun     <= ovr_n;
`ifdef SN_BIPOLAR_EN
      bip_out     <= $signed({cnt_n, 1'b0} - BIP_W'(WINDOW));
`endif
    end
  end

  // Next-state, accumulation and result handoff
  always_comb begin
    state_n = state;
    acc_n   = acc;
    smp_n   = smp;
    cnt_n   = count_out;
    vld_n   = count_valid;
    ovr_n   = overrun;
    done    = 1'b0;
    result  = acc + CNT_W'(sn_bit);

    if (count_valid && count_ready) vld_n = 1'b0;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n = ACCUM;
          acc_n   = '0;
          smp_n   = '0;
        end
      end
      ACCUM: begin
        if (stop) begin
          state_n = IDLE;
          acc_n   = '0;
          smp_n   = '0;
        end else if (sn_valid) begin
          if (smp == SMP_W'(WINDOW - 1)) begin
            done    = 1'b1;
            acc_n   = '0;
            smp_n   = '0;
            state_n = cont ? ACCUM : IDLE;
          end else begin
            acc_n = result;
            smp_n = smp + SMP_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (ovr_clr) ovr_n = 1'b0;

    // A pending, unaccepted result is kept; the new one is dropped and flagged
    if (done) begin
      if (!count_valid || count_ready) begin
        cnt_n = result;
        vld_n = 1'b1;
      end else begin
        ovr_n = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sn_window_decoder.sv
// Scoreboard bench for sn_window_decoder (WINDOW=8); a negedge monitor checks each
// accepted result against the queue of hand-computed counts.
module tb_sn_window_decoder;

  localparam int unsigned WINDOW = 8;
  localparam int unsigned CNT_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sn_bit, sn_valid, start, stop, cont;
  logic [CNT_W-1:0] count_out;
  logic             count_valid, count_ready, busy, overrun, ovr_clr;
`ifdef SN_BIPOLAR_EN
  logic signed [CNT_W:0] bip_out;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  sn_window_decoder #(.WINDOW(WINDOW)) dut (
    .clk(clk), .rst_n(rst_n), .sn_bit(sn_bit), .sn_valid(sn_valid),
    .start(start), .stop(stop), .cont(cont),
    .count_out(count_out), .count_valid(count_valid), .count_ready(count_ready),
    .busy(busy), .overrun(overrun), .ovr_clr(ovr_clr)
`ifdef SN_BIPOLAR_EN
    , .bip_out(bip_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sn_bit   = b;
    sn_valid = 1'b1;
    step();
    sn_valid = 1'b0;
  endtask

  // Sends the first n bits of a listed-order pattern (MSB first), optional idle gaps
  task automatic send_bits(input logic [7:0] bits, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      send_bit(bits[7-i]);
      if (gaps && (i % 2 == 1)) step();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, int'(count_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_count"}, int'(count_out), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
`ifdef SN_BIPOLAR_EN
    check({tag, "_bip"}, int'(bip_out), -8);
`endif
  endtask

  // Monitor: every accepted result is compared against the scoreboard queue
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && count_valid && count_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", int'(count_out), -1);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("sb_count", int'(count_out), e);
`ifdef SN_BIPOLAR_EN
          check("sb_bip", int'(bip_out), 2 * e - int'(WINDOW));
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    check("watchdog", 0, 1);
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  initial begin
    rst_n = 1'b0; sn_bit = 1'b0; sn_valid = 1'b0; start = 1'b0; stop = 1'b0;
    cont = 1'b0; count_ready = 1'b0; ovr_clr = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check_reset_vals("reset");

    // Valid stream without start must not accumulate or produce
    sn_bit = 1'b1; sn_valid = 1'b1;
    repeat (20) step();
    sn_valid = 1'b0;
    check_reset_vals("idle_stream");

    // One-shot window with gaps: 1,0,1,1,0,0,1,0 -> 4
    pulse_start();
    check("oneshot_busy", int'(busy), 1);
    send_bits(8'b1011_0010, 7, 1'b1);
    check("oneshot_not_yet", int'(count_valid), 0);
    exp_q.push_back(4);
    send_bit(1'b0);
    check("oneshot_valid", int'(count_valid), 1);
    check("oneshot_count", int'(count_out), 4);
    check("oneshot_idle", int'(busy), 0);
    step();
    check("oneshot_hold", int'(count_out), 4);
    count_ready = 1'b1;
    step();
    check("oneshot_cleared", int'(count_valid), 0);

    // Full window: no wrap
    pulse_start();
    exp_q.push_back(8);
    send_bits(8'hFF, 8, 1'b0);
    check("full_count", int'(count_out), 8);
`ifdef SN_BIPOLAR_EN
    check("full_bip", int'(bip_out), 8);
`endif
    step();

    // Empty window
    pulse_start();
    exp_q.push_back(0);
    send_bits(8'h00, 8, 1'b0);
    check("empty_valid", int'(count_valid), 1);
    check("empty_count", int'(count_out), 0);
`ifdef SN_BIPOLAR_EN
    check("empty_bip", int'(bip_out), -8);
`endif
    step();

    // Continuous mode with backpressure
    count_ready = 1'b0; cont = 1'b1;
    pulse_start();
    exp_q.push_back(8);
    send_bits(8'hFF, 8, 1'b0);
    check("cont_w1_valid", int'(count_valid), 1);
    check("cont_w1_busy", int'(busy), 1);
    send_bits(8'hFF, 8, 1'b0);
    check("cont_w2_overrun", int'(overrun), 1);
    check("cont_w2_kept", int'(count_out), 8);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("ovr_cleared", int'(overrun), 0);
    // Handshake coincides with completion: new result loads with no bubble
    send_bits(8'hFF, 7, 1'b0);
    exp_q.push_back(8);
    count_ready = 1'b1;
    send_bit(1'b1);
    check("b2b_valid", int'(count_valid), 1);
    check("b2b_no_overrun", int'(overrun), 0);
    cont = 1'b0;
    check("cont_still_busy", int'(busy), 1);
    exp_q.push_back(3);
    send_bits(8'b1110_0000, 8, 1'b0);
    check("w4_count", int'(count_out), 3);
    check("w4_idle", int'(busy), 0);
    step();
    check("w4_consumed", int'(count_valid), 0);

    // Abort after 5 ones, then restart proves accumulator cleared
    pulse_start();
    send_bits(8'hFF, 5, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("abort_idle", int'(busy), 0);
    check("abort_no_result", int'(count_valid), 0);
    pulse_start();
    exp_q.push_back(0);
    send_bits(8'h00, 8, 1'b0);
    check("restart_count", int'(count_out), 0);
    step();
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("stop_start_idle", int'(busy), 0);

    // stop beats a completing bit
    pulse_start();
    send_bits(8'hFF, 7, 1'b0);
    stop = 1'b1;
    send_bit(1'b1);
    stop = 1'b0;
    check("stop_vs_done_valid", int'(count_valid), 0);
    check("stop_vs_done_busy", int'(busy), 0);

    // Reset mid-window while a result is pending
    count_ready = 1'b0; cont = 1'b1;
    pulse_start();
    send_bits(8'hFF, 8, 1'b0);
    check("pre_reset_valid", int'(count_valid), 1);
    send_bits(8'hFF, 4, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_reset_vals("mid_reset");
    cont = 1'b0; count_ready = 1'b1;
    pulse_start();
    exp_q.push_back(4);
    send_bits(8'b0101_0101, 8, 1'b0);
    check("post_reset_count", int'(count_out), 4);
    step(); step();
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sn_window_decoder.md
Name: sn_window_decoder

Overview:
- Downstream back-converter for the stochastic datapath: consumes the serial stochastic bitstream produced by the SN adder/MUX stage.
- Counts ones over a fixed window of WINDOW qualified bits; presents the count on a valid/ready output register.
- Exact count 0..WINDOW, so there is no overflow flag. Supports one-shot and continuous operation, abort, and sticky overrun reporting.

Parameters:
- WINDOW, 8, number of qualified stream bits per window; >=2.
- CNT_W, $clog2(WINDOW+1), width of count; holds 0..WINDOW inclusive.
- SMP_W, $clog2(WINDOW), width of sample index.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- sn_bit  in  1  stochastic stream bit.
- sn_valid  in  1  sn_bit qualified this cycle.
- start  in  1  pulse: begin a window from IDLE.
- stop  in  1  pulse: abort the current window and return to IDLE.
- cont  in  1  continuous mode; sampled at each window completion.
- count_out  out  CNT_W  ones count of the last completed window.
- count_valid  out  1  count_out holds an unconsumed result.
- count_ready  in  1  consumer accepts; transfer when count_valid && count_ready.
- busy  out  1  high while in ACCUM.
- overrun  out  1  sticky: a window completed while the previous result was still pending.
- ovr_clr  in  1  clears overrun.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, acc=0, smp=0, count_out=0, count_valid=0, busy=0, overrun=0. Reset overrides all other inputs, including mid-window; the partial window is discarded.
- States: IDLE, ACCUM.
- IDLE -> ACCUM when start=1 and stop=0. On entry acc=0 and smp=0. sn_valid in the start cycle is ignored.
- ACCUM, sn_valid=1 and smp<WINDOW-1: acc <= acc+sn_bit, smp <= smp+1.
- ACCUM, sn_valid=1 and smp==WINDOW-1 (window complete): result = acc+sn_bit. acc and smp clear. Next state is ACCUM if cont=1, else IDLE.
- ACCUM, sn_valid=0: hold acc and smp. There is no timeout.
- stop=1 in ACCUM -> IDLE next cycle; acc and smp clear; no result is produced.
- stop wins over start and over a completing bit in the same cycle.
- start while in ACCUM is ignored.
- Output register:
  - count_valid rises the cycle after the completing bit; latency is 1 clk from the last sn_valid edge.
  - count_out is stable while count_valid=1.
  - count_valid clears the cycle after a handshake.
- Completion with a pending result:
  - If count_valid=1 and count_ready=1 in the completion cycle, the new result loads (back-to-back, no bubble) and count_valid stays 1.
  - If count_valid=1 and count_ready=0, the new result is dropped, the old result is kept, and overrun <= 1.
- overrun:
  - Cleared by ovr_clr; if ovr_clr and a new overrun event coincide, set wins.
  - Never cleared by a handshake.
- busy = (state==ACCUM), registered.
- Arithmetic: acc is CNT_W wide, unsigned. WINDOW ones gives count_out=WINDOW with no wrap. smp wraps only via explicit clear at completion.
- count_ready with count_valid=0: no effect.

Optional Feature:
- Macro SN_BIPOLAR_EN.
- When defined: adds output port bip_out, CNT_W+1 bits, two's complement, = 2*count_out - WINDOW. It is registered alongside count_out, valid under count_valid, and resets to -WINDOW. This is the bipolar value scaled by WINDOW; range -WINDOW..+WINDOW.
- When undefined: the port is absent and the logic is identical otherwise.

Test Plan:
- Reset/idle: rst_n=0 for 2 clk, then start=0 for 20 clk with sn_valid=1 -> count_valid=0, busy=0, count_out=0, overrun=0.
- One-shot (WINDOW=8): start, then 8 valid bits 1,0,1,1,0,0,1,0 with sn_valid gaps inserted -> count_out=4, count_valid=1 exactly 1 clk after the 8th valid bit, state IDLE, busy=0. With count_ready=1, count_valid clears the next cycle.
- Full/empty: 8 ones -> count_out=8 (no wrap); 8 zeros -> count_out=0; with SN_BIPOLAR_EN, bip_out=+8 and -8 respectively.
- Continuous with backpressure: cont=1, count_ready=0, all-ones stream -> first window count_valid=1, count_out=8. Second window completes -> overrun=1, count_out still 8. ovr_clr pulse -> overrun=0. Then count_ready=1 -> results stream back-to-back every 8 valid cycles.
- Abort: start, 5 valid ones, stop -> IDLE, no count_valid. Restart with 8 zeros -> count_out=0, proving acc was cleared. stop and start asserted together in IDLE -> stays IDLE.
- Reset mid-window: 4 valid ones, then rst_n=0 for 1 clk while count_valid=1 -> all outputs return to reset values next edge.
